// File: rtl/mux_pkg.sv
// Shared definitions for the channel scan multiplexer: mode encodings and clog2.
// Optional sel_err output is enabled by CHANNEL_SCAN_MUX_SEL_ERR_EN (see channel_scan_mux).
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DWELL_CNT_W = 8;

  // Ceiling log2, never below 1 so a select port always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_ptr.sv
// Dwell counter and rotating next-enabled-channel search used by the auto-scan mode.
// The caller owns cur_ch; this block only says when to move and where to.
module scan_ptr
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DWELL = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [SEL_W-1:0] cur_ch,
  output logic             adv,
  output logic [SEL_W-1:0] next_ch
);

  localparam int SLOTS = 1 << SEL_W;
  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);
  localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL - 1);

  logic [SLOTS-1:0]       en_pad;
  logic [SEL_W:0]         rot_sum [N_CH];
  logic [SEL_W-1:0]       rot_idx [N_CH];
  logic [N_CH-1:0]        rot_en;
  logic [DWELL_CNT_W-1:0] dwell_reg;
  logic [DWELL_CNT_W-1:0] dwell_next;
  logic                   cur_en;
  logic                   any_en;
  logic                   expired;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_pad
      if (gi < N_CH) begin : g_real
        assign en_pad[gi] = ch_en[gi];
      end else begin : g_fill
        assign en_pad[gi] = 1'b0;
      end
    end

    // Slot gi is the channel gi+1 places above cur_ch; the last slot wraps back to cur_ch.
    for (gi = 0; gi < N_CH; gi++) begin : g_rot
      assign rot_sum[gi] = {1'b0, cur_ch} + (SEL_W + 1)'(gi + 1);
      assign rot_idx[gi] = (rot_sum[gi] >= N_CH_W) ? SEL_W'(rot_sum[gi] - N_CH_W)
                                                   : SEL_W'(rot_sum[gi]);
      assign rot_en[gi]  = en_pad[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    next_ch = cur_ch;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot_en[i]) next_ch = rot_idx[i];
    end
  end

  assign cur_en  = en_pad[cur_ch];
  assign any_en  = |ch_en;
  assign expired = (dwell_reg == DWELL_LAST);
  assign adv     = run && any_en && (!cur_en || expired);

  always_comb begin
    dwell_next = dwell_reg;
    if (clr) begin
      dwell_next = '0;
    end else if (run && any_en) begin
      if (adv) dwell_next = '0;
      else     dwell_next = dwell_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dwell_reg <= '0;
    else        dwell_reg <= dwell_next;
  end

endmodule

// File: rtl/channel_scan_mux.sv
// Registered N-channel mux with manual select or dwell-timed auto-scan over enabled channels.
// Define CHANNEL_SCAN_MUX_SEL_ERR_EN to add the sticky sel_err output.
module channel_scan_mux
  import mux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   din,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic [N_CH-1:0]          ch_en,
  input  logic                     hold,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     dout_valid
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
  ,
  output logic                     sel_err
`endif
);

  localparam int SLOTS = 1 << SEL_W;
  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

  logic [DATA_W-1:0] ch_data [SLOTS];
  logic [SLOTS-1:0]  en_pad;
  logic [SEL_W-1:0]  cur_ch_reg;
  logic [SEL_W-1:0]  cur_ch_next;
  logic [DATA_W-1:0] dout_reg;
  logic              dout_valid_reg;
  logic              is_manual;
  logic              sel_ok;
  logic              adv;
  logic [SEL_W-1:0]  next_ch;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_unpack
      if (gi < N_CH) begin : g_real
        assign ch_data[gi] = din[gi*DATA_W +: DATA_W];
        assign en_pad[gi]  = ch_en[gi];
      end else begin : g_fill
        assign ch_data[gi] = '0;
        assign en_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  assign is_manual = (mode_e'(mode) == MODE_MANUAL);
  assign sel_ok    = ({1'b0, sel} < N_CH_W);

  // Manual mode keeps the dwell counter cleared, so any mode change starts a fresh dwell.
  scan_ptr #(
    .N_CH  (N_CH),
    .DWELL (DWELL),
    .SEL_W (SEL_W)
  ) u_scan_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (!hold && !is_manual),
    .clr     (!hold && is_manual),
    .ch_en   (ch_en),
    .cur_ch  (cur_ch_reg),
    .adv     (adv),
    .next_ch (next_ch)
  );

  always_comb begin
    cur_ch_next = cur_ch_reg;
    if (!hold) begin
      if (is_manual) begin
        if (sel_ok) cur_ch_next = sel;
      end else if (adv) begin
        cur_ch_next = next_ch;
      end
    end
  end

  // dout/dout_valid sample the pre-update cur_ch, giving the one-cycle lag behind cur_ch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_ch_reg     <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      cur_ch_reg     <= cur_ch_next;
      dout_reg       <= ch_data[cur_ch_reg];
      dout_valid_reg <= en_pad[cur_ch_reg];
    end
  end

  assign cur_ch     = cur_ch_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
  logic sel_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)                   sel_err_reg <= 1'b0;
    else if (is_manual && !sel_ok) sel_err_reg <= 1'b1;
  end

  assign sel_err = sel_err_reg;
`else
  // Out-of-range manual selects are simply ignored.
`endif

endmodule

// File: tb/tb_channel_scan_mux.sv
// Directed self-checking bench: N_CH=4/DWELL=3 main instance plus an N_CH=3 instance for out-of-range sel.
// Define CHANNEL_SCAN_MUX_SEL_ERR_EN to also check the sticky sel_err flag.
module tb_channel_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  ch_en;
  logic        hold;
  logic [7:0]  dout;
  logic [1:0]  cur_ch;
  logic        dout_valid;

  logic [23:0] din_b;
  logic [1:0]  sel_b;
  logic        mode_b;
  logic [2:0]  ch_en_b;
  logic        hold_b;
  logic [7:0]  dout_b;
  logic [1:0]  cur_ch_b;
  logic        dout_valid_b;
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
  logic        sel_err;
  logic        sel_err_b;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  channel_scan_mux #(.N_CH(4), .DATA_W(8), .DWELL(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .sel        (sel),
    .mode       (mode),
    .ch_en      (ch_en),
    .hold       (hold),
    .dout       (dout),
    .cur_ch     (cur_ch),
    .dout_valid (dout_valid)
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
    ,
    .sel_err    (sel_err)
`endif
  );

  channel_scan_mux #(.N_CH(3), .DATA_W(8), .DWELL(3)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_b),
    .sel        (sel_b),
    .mode       (mode_b),
    .ch_en      (ch_en_b),
    .hold       (hold_b),
    .dout       (dout_b),
    .cur_ch     (cur_ch_b),
    .dout_valid (dout_valid_b)
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
    ,
    .sel_err    (sel_err_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      $display("check %-16s observed=%0h expected=%0h ok", tag, observed, expected);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int scan_seq [9] = '{0, 0, 1, 1, 1, 3, 3, 3, 0};

  initial begin
    rst_n   = 1'b0;
    din     = 32'hDDCC_BBAA;
    sel     = 2'd0;
    mode    = 1'b0;
    ch_en   = 4'hF;
    hold    = 1'b0;
    din_b   = 24'hCC_BBAA;
    sel_b   = 2'd0;
    mode_b  = 1'b0;
    ch_en_b = 3'b111;
    hold_b  = 1'b0;

    // Reset held for two edges
    repeat (2) tick();
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_cur_ch_b", 32'(cur_ch_b), 32'd0);
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
    check("rst_sel_err_b", 32'(sel_err_b), 32'd0);
`endif

    // Manual select
    rst_n = 1'b1;
    sel   = 2'd2;
    sel_b = 2'd1;
    tick();
    check("man_cur_ch", 32'(cur_ch), 32'd2);
    check("man_dout_lag", 32'(dout), 32'hAA);
    check("man_cur_ch_b", 32'(cur_ch_b), 32'd1);

    sel_b = 2'd3;
    tick();
    check("man_dout", 32'(dout), 32'hCC);
    check("man_valid", 32'(dout_valid), 32'd1);
    check("oob_cur_ch_b", 32'(cur_ch_b), 32'd1);
    check("oob_dout_b", 32'(dout_b), 32'hBB);
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
    check("sel_err_set", 32'(sel_err_b), 32'd1);
`endif

    sel   = 2'd0;
    sel_b = 2'd0;
    tick();
    check("man_back_0", 32'(cur_ch), 32'd0);
    check("cur_ch_b_0", 32'(cur_ch_b), 32'd0);
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
    check("sel_err_sticky", 32'(sel_err_b), 32'd1);
`endif

    // Scan with channel 2 masked out
    mode  = 1'b1;
    ch_en = 4'b1011;
    check("scan_start", 32'(cur_ch), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("scan_seq%0d", i + 1), 32'(cur_ch), 32'(scan_seq[i]));
    end
    check("scan_dout", 32'(dout), 32'hDD);

    // Move onto channel 1 mid-dwell, then disable it
    repeat (3) tick();
    check("scan_on_1", 32'(cur_ch), 32'd1);
    tick();
    check("mid_dwell_1", 32'(cur_ch), 32'd1);
    ch_en = 4'b1001;
    tick();
    check("disable_jump", 32'(cur_ch), 32'd3);
    check("disable_valid", 32'(dout_valid), 32'd0);
    tick();
    check("restart_d1", 32'(cur_ch), 32'd3);
    tick();
    check("restart_d2", 32'(cur_ch), 32'd3);
    tick();
    check("restart_wrap", 32'(cur_ch), 32'd0);

    // Hold freezes cur_ch while dout keeps tracking din
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d", i), 32'(cur_ch), 32'd0);
    end
    din = 32'hDDCC_BB5A;
    tick();
    check("hold_dout_track", 32'(dout), 32'h5A);
    check("hold_still", 32'(cur_ch), 32'd0);
    din  = 32'hDDCC_BBAA;
    hold = 1'b0;

    // Empty mask
    ch_en = 4'b0000;
    tick();
    check("empty_cur", 32'(cur_ch), 32'd0);
    check("empty_valid", 32'(dout_valid), 32'd0);
    tick();
    check("empty_cur2", 32'(cur_ch), 32'd0);
    check("empty_valid2", 32'(dout_valid), 32'd0);

    // Single enabled channel
    ch_en = 4'b0100;
    tick();
    check("single_jump", 32'(cur_ch), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("single_stay%0d", i), 32'(cur_ch), 32'd2);
    end
    check("single_valid", 32'(dout_valid), 32'd1);
    check("single_dout", 32'(dout), 32'hCC);

    // Mode round trip restarts the dwell from the current channel
    mode = 1'b0;
    sel  = 2'd1;
    tick();
    check("to_manual", 32'(cur_ch), 32'd1);
    mode  = 1'b1;
    ch_en = 4'hF;
    tick();
    check("rescan_d1", 32'(cur_ch), 32'd1);
    tick();
    check("rescan_d2", 32'(cur_ch), 32'd1);
    tick();
    check("rescan_adv", 32'(cur_ch), 32'd2);

    // Reset mid-dwell, then scan resumes from channel 0 with a fresh dwell
    tick();
    rst_n = 1'b0;
    tick();
    check("rst2_cur_ch", 32'(cur_ch), 32'd0);
    check("rst2_dout", 32'(dout), 32'h00);
    check("rst2_valid", 32'(dout_valid), 32'd0);
`ifdef CHANNEL_SCAN_MUX_SEL_ERR_EN
    check("sel_err_clear", 32'(sel_err_b), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("post_rst_d1", 32'(cur_ch), 32'd0);
    tick();
    check("post_rst_d2", 32'(cur_ch), 32'd0);
    tick();
    check("post_rst_adv", 32'(cur_ch), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
